// File: rtl/ifmap_window_scheduler_pkg.sv
// Shared types and default sizing for the IFMap window scheduler.
package ifmap_pkg;

    localparam int DEF_POINTER_SIZE = 8;
    localparam int DEF_STRIDE_SIZE  = 3;
    localparam int DEF_IFMAP_SIZE   = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_READ      = 3'd2,
        ST_ADVANCE   = 3'd3,
        ST_ROW_END   = 3'd4
    } sched_state_t;

endpackage

// File: rtl/ifmap_window_scheduler_if.sv
// Read port between the window scheduler and the IFMap buffer.
// master = scheduler (issues reads), slave = buffer side (grants them).
interface ifmap_window_scheduler_if
    import ifmap_pkg::*;
#(
    parameter int POINTER_SIZE = DEF_POINTER_SIZE
);

    logic                    rd_ready;
    logic                    rd_en;
    logic [POINTER_SIZE-1:0] rd_ptr;
    logic                    win_first;
    logic                    win_last;

    modport master (
        input  rd_ready,
        output rd_en,
        output rd_ptr,
        output win_first,
        output win_last
    );

    modport slave (
        output rd_ready,
        input  rd_en,
        input  rd_ptr,
        input  win_first,
        input  win_last
    );

endinterface

// File: rtl/ifmap_window_scheduler_ptr_wrap.sv
// Combinational modular adder: (base + offset) mod IFMAP_SIZE.
// A single compare-subtract is enough because base is always a valid
// buffer index and the offset never exceeds one row, which has to fit
// in the buffer.  Works for non-power-of-two depths.
module ifmap_ptr_wrap
    import ifmap_pkg::*;
#(
    parameter int POINTER_SIZE = DEF_POINTER_SIZE,
    parameter int IFMAP_SIZE   = DEF_IFMAP_SIZE
) (
    input  logic [POINTER_SIZE-1:0] base,
    input  logic [POINTER_SIZE-1:0] offset,
    output logic [POINTER_SIZE-1:0] result
);

    localparam logic [POINTER_SIZE:0] DEPTH = (POINTER_SIZE+1)'(IFMAP_SIZE);

    logic [POINTER_SIZE:0] sum;
    logic [POINTER_SIZE:0] sum_sub;

    assign sum     = {1'b0, base} + {1'b0, offset};
    assign sum_sub = sum - DEPTH;
    assign result  = (sum >= DEPTH) ? sum_sub[POINTER_SIZE-1:0] : sum[POINTER_SIZE-1:0];

endmodule

// File: rtl/ifmap_window_scheduler.sv
// Sliding-window read scheduler for a circular IFMap buffer.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for start; bad config pulses cfg_err and stays here
// WAIT_DATA  | holding until the buffer holds the whole current window
// READ       | issuing one read per rd_ready cycle, k walks the window
// ADVANCE    | step win_off by stride, or give up the row if it won't fit
// ROW_END    | release the row (next_row/end_row), move row_base on
module ifmap_window_scheduler
    import ifmap_pkg::*;
#(
    parameter int POINTER_SIZE = DEF_POINTER_SIZE,
    parameter int STRIDE_SIZE  = DEF_STRIDE_SIZE,
    parameter int IFMAP_SIZE   = DEF_IFMAP_SIZE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [POINTER_SIZE-1:0] cfg_start_ptr,
    input  logic [POINTER_SIZE-1:0] cfg_row_len,
    input  logic [POINTER_SIZE-1:0] cfg_filter_len,
    input  logic [STRIDE_SIZE-1:0]  cfg_stride,
    input  logic [POINTER_SIZE-1:0] cfg_num_rows,
    input  logic [POINTER_SIZE-1:0] buf_count,
    ifmap_window_scheduler_if.master rd,
    output logic                    next_row,
    output logic                    end_row,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err
);

    localparam int PS = POINTER_SIZE;

    sched_state_t state_q, state_n;

    logic [PS-1:0]          row_base_q, row_base_n;
    logic [PS-1:0]          win_off_q, win_off_n;
    logic [PS-1:0]          k_q, k_n;
    logic [PS-1:0]          rows_left_q, rows_left_n;
    logic [PS-1:0]          row_len_q, row_len_n;
    logic [PS-1:0]          filter_len_q, filter_len_n;
    logic [STRIDE_SIZE-1:0] stride_q, stride_n;
    logic [PS-1:0]          rd_ptr_q, rd_ptr_n;

    logic next_row_q, next_row_n;
    logic busy_q, busy_n;
    logic done_q, done_n;
    logic cfg_err_q, cfg_err_n;

    logic          cfg_bad;
    logic          xfer;
    logic [PS-1:0] k_last;
    logic [PS:0]   need_cnt;
    logic [PS:0]   adv_off;
    logic [PS:0]   adv_end;
    logic [PS-1:0] row_wrap;
    logic [PS-1:0] ptr_off_n;

    // Configurations that cannot produce a single complete window.
    assign cfg_bad = (cfg_filter_len == '0) || (cfg_row_len == '0) ||
                     (cfg_filter_len > cfg_row_len) || (cfg_num_rows == '0);

    // Read strobe and window markers follow rd_ready without a register
    // stage so a stalled cycle never issues a read.
    assign xfer         = (state_q == ST_READ) && rd.rd_ready;
    assign k_last       = filter_len_q - PS'(1);
    assign rd.rd_en     = xfer;
    assign rd.win_first = xfer && (k_q == '0);
    assign rd.win_last  = xfer && (k_q == k_last);
    assign rd.rd_ptr    = rd_ptr_q;

    // One extra bit on every sum so the compares cannot overflow.
    assign need_cnt = {1'b0, win_off_q} + {1'b0, filter_len_q};
    assign adv_off  = {1'b0, win_off_q} + (PS+1)'(stride_q);
    assign adv_end  = adv_off + {1'b0, filter_len_q};

    assign next_row = next_row_q;
    assign end_row  = next_row_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cfg_err  = cfg_err_q;

    ifmap_ptr_wrap #(
        .POINTER_SIZE (PS),
        .IFMAP_SIZE   (IFMAP_SIZE)
    ) u_row_wrap (
        .base   (row_base_q),
        .offset (row_len_q),
        .result (row_wrap)
    );

    // rd_ptr is registered, so it is computed from the next-state values
    // and is already correct in the cycle the read is issued.
    ifmap_ptr_wrap #(
        .POINTER_SIZE (PS),
        .IFMAP_SIZE   (IFMAP_SIZE)
    ) u_ptr_wrap (
        .base   (row_base_n),
        .offset (ptr_off_n),
        .result (rd_ptr_n)
    );

    // Next-state, datapath updates and registered output values.
    always_comb begin
        state_n      = state_q;
        row_base_n   = row_base_q;
        win_off_n    = win_off_q;
        k_n          = k_q;
        rows_left_n  = rows_left_q;
        row_len_n    = row_len_q;
        filter_len_n = filter_len_q;
        stride_n     = stride_q;
        next_row_n   = 1'b0;
        done_n       = 1'b0;
        cfg_err_n    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        cfg_err_n = 1'b1;
                    end else begin
                        row_len_n    = cfg_row_len;
                        filter_len_n = cfg_filter_len;
                        stride_n     = (cfg_stride == '0) ? STRIDE_SIZE'(1) : cfg_stride;
                        row_base_n   = cfg_start_ptr;
                        win_off_n    = '0;
                        k_n          = '0;
                        rows_left_n  = cfg_num_rows;
                        state_n      = ST_WAIT_DATA;
                    end
                end
            end
            ST_WAIT_DATA: begin
                if ({1'b0, buf_count} >= need_cnt) begin
                    state_n = ST_READ;
                end
            end
            ST_READ: begin
                if (xfer) begin
                    if (k_q == k_last) begin
                        k_n     = '0;
                        state_n = ST_ADVANCE;
                    end else begin
                        k_n = k_q + PS'(1);
                    end
                end
            end
            ST_ADVANCE: begin
                if (adv_end <= {1'b0, row_len_q}) begin
                    win_off_n = adv_off[PS-1:0];
                    state_n   = ST_WAIT_DATA;
                end else begin
                    // next_row/done are registered, so raise them on the
                    // way into ROW_END to land in that cycle.
                    next_row_n = 1'b1;
                    done_n     = (rows_left_q == PS'(1));
                    state_n    = ST_ROW_END;
                end
            end
            ST_ROW_END: begin
                row_base_n  = row_wrap;
                win_off_n   = '0;
                rows_left_n = rows_left_q - PS'(1);
                state_n     = (rows_left_q == PS'(1)) ? ST_IDLE : ST_WAIT_DATA;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        busy_n    = (state_n != ST_IDLE);
        ptr_off_n = win_off_n + k_n;
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            row_base_q   <= '0;
            win_off_q    <= '0;
            k_q          <= '0;
            rows_left_q  <= '0;
            row_len_q    <= '0;
            filter_len_q <= '0;
            stride_q     <= '0;
            rd_ptr_q     <= '0;
            next_row_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_n;
            row_base_q   <= row_base_n;
            win_off_q    <= win_off_n;
            k_q          <= k_n;
            rows_left_q  <= rows_left_n;
            row_len_q    <= row_len_n;
            filter_len_q <= filter_len_n;
            stride_q     <= stride_n;
            rd_ptr_q     <= rd_ptr_n;
            next_row_q   <= next_row_n;
            busy_q       <= busy_n;
            done_q       <= done_n;
            cfg_err_q    <= cfg_err_n;
        end
    end

endmodule

// File: doc/ifmap_window_scheduler.md
IFMAP_WINDOW_SCHEDULER -- requirements
Module: ifmap_window_scheduler

Interface
REQ-001 Parameters SHALL be: POINTER_SIZE, default 8, pointer/count width; STRIDE_SIZE, default 3, stride width; IFMAP_SIZE, default 16, circular IFMap buffer depth in entries.
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; latches configuration.
- cfg_start_ptr  in  POINTER_SIZE  buffer index of the first element of row 0.
- cfg_row_len  in  POINTER_SIZE  elements per row.
- cfg_filter_len  in  POINTER_SIZE  window length.
- cfg_stride  in  STRIDE_SIZE  window step.
- cfg_num_rows  in  POINTER_SIZE  rows to process.
- buf_count  in  POINTER_SIZE  valid elements currently in the buffer from the current row base.
- rd_ready  in  1  downstream accepts a read this cycle.
- rd_en  out  1  read strobe.
- rd_ptr  out  POINTER_SIZE  buffer read address.
- win_first  out  1  rd_en element is window element 0.
- win_last  out  1  rd_en element is the last window element.
- next_row  out  1  one-cycle row-release pulse to the IFMap buffer controller.
- end_row  out  1  high with next_row.
- busy  out  1  not IDLE.
- done  out  1  one-cycle pulse after the last row.
- cfg_err  out  1  one-cycle pulse on illegal configuration.

Function
REQ-003 The FSM SHALL have states IDLE, WAIT_DATA, READ, ADVANCE and ROW_END.
REQ-004 In IDLE, start SHALL latch all cfg_* inputs, then:
- set row_base=cfg_start_ptr, win_off=0, k=0, rows_left=cfg_num_rows;
- go to WAIT_DATA the next cycle.
REQ-005 start outside IDLE SHALL be ignored.
REQ-006 A latched stride of 0 SHALL be treated as 1.
REQ-007 If cfg_filter_len==0, cfg_row_len==0, cfg_filter_len>cfg_row_len or cfg_num_rows==0 at start, the block SHALL pulse cfg_err next cycle and remain IDLE.
REQ-008 WAIT_DATA SHALL go to READ when buf_count >= win_off+filter_len; otherwise it SHALL hold.
REQ-009 In READ, rd_en SHALL equal rd_ready.
REQ-010 rd_ptr SHALL be (row_base+win_off+k) mod IFMAP_SIZE, using a compare-subtract wrap, valid for non-power-of-two depths.
REQ-011 k SHALL increment only when rd_en=1.
REQ-012 rd_ready=0 SHALL freeze rd_ptr, k and state.
REQ-013 win_first SHALL be rd_en&&(k==0); win_last SHALL be rd_en&&(k==filter_len-1).
REQ-014 After the win_last transfer, the FSM SHALL clear k and enter ADVANCE.
REQ-015 filter_len==1 SHALL assert win_first and win_last together.
REQ-016 ADVANCE (one cycle) SHALL compute n=win_off+stride:
- if n+filter_len <= row_len: win_off=n, go to WAIT_DATA;
- otherwise go to ROW_END.
REQ-017 ROW_END (one cycle) SHALL assert next_row and end_row.
REQ-018 ROW_END SHALL update row_base=(row_base+row_len) mod IFMAP_SIZE, win_off=0 and rows_left-1.
REQ-019 From ROW_END, the FSM SHALL go to IDLE with done pulsed in that same ROW_END cycle if rows_left was 1; otherwise it SHALL go to WAIT_DATA.
REQ-020 Internal sums SHALL be POINTER_SIZE+1 bits so that compares never overflow.
REQ-021 All outputs SHALL be registered, except that rd_en, win_first and win_last are combinational from state, k and rd_ready.
REQ-022 Zero-stall throughput SHALL be filter_len reads per window plus 1 ADVANCE cycle plus 1 WAIT_DATA cycle.

Reset
REQ-023 rst_n=0 at a clock edge SHALL, mid-operation or not:
- force IDLE;
- clear row_base, win_off, k and rows_left;
- drive every output to 0.
REQ-024 start coincident with rst_n=0 SHALL be ignored.

Structure
REQ-025 A shared package ifmap_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-026 One sub-module, ifmap_ptr_wrap, SHALL be used. It is a combinational modular adder (base+offset mod IFMAP_SIZE) used for rd_ptr and the row_base update.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Basic row: row_len=8, filter_len=3, stride=2, num_rows=1, start_ptr=0, buf_count=8, rd_ready=1 -> windows at offsets 0,2,4; reads 0,1,2,2,3,4,4,5,6; one next_row; done.
- Wrap: start_ptr=14, row_len=6, filter_len=2, stride=4, IFMAP_SIZE=16 -> rd_ptr 14,15,2,3; second row base = 4.
- Stall and starve: buf_count held at 2 with filter_len=3 -> no rd_en; raise it to 3 -> reads resume. rd_ready low for 3 cycles on k=1 -> rd_ptr is held and no element is skipped.
- Illegal configuration: filter_len=5, row_len=4 -> cfg_err pulse, busy stays 0. stride=0 -> behaves as stride 1.
- Mid-run reset: assert rst_n=0 during READ -> all outputs 0 next cycle. A new start then runs cleanly, and a start while busy is ignored.
